// File: rtl/data_mem_resp_pkg.sv
// Shared types and default sizing for the data memory responder.
package data_mem_resp_pkg;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   localparam int unsigned DefDepthWords = 1024;
   localparam int unsigned DefLatency    = 2;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage: byte-strobed synchronous write, registered read, no reset.
module data_mem_array
   import data_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DefDepthWords,
   parameter int unsigned AW          = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wstrb,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      // Read register only moves on a load, so it stays stable while a response is held.
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_resp.sv
// Single-outstanding memory responder with fixed request-to-response latency.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DefDepthWords,
   parameter int unsigned LATENCY     = DefLatency
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, err_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;

   logic        accept, enter_resp;
   logic        acc_we, acc_err;
   logic [31:0] acc_addr, acc_wdata;
   logic [3:0]  acc_wstrb;
   logic        mem_we, mem_re;
   logic [31:0] mem_rdata;

   assign accept = req_valid && req_ready;

   // With LATENCY=1 the access happens on the accepting edge, so use the live request.
   always_comb begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
      if (state_q == StIdle) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end
   end

   assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
   assign enter_resp = (state_d == StResp) && (state_q != StResp) && !rst;
   assign mem_we     = enter_resp && acc_we && !acc_err;
   assign mem_re     = enter_resp && !acc_we && !acc_err;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (LATENCY > 1) begin
                  state_d = StBusy;
                  cnt_d   = 4'(LATENCY - 2);
               end else begin
                  state_d = StResp;
               end
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
         end
         if (enter_resp) err_q <= acc_err;
      end
   end

   data_mem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .re   (mem_re),
      .addr (acc_addr[AW+1:2]),
      .wdata(acc_wdata),
      .wstrb(acc_wstrb),
      .rdata(mem_rdata)
   );

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !we_q && !err_q) ? mem_rdata : 32'h0;

endmodule
